// File: rtl/decode_regfile.sv
// Decode and register-file stage: splits the fetched instruction into fields, holds the
// 32-entry register file, and returns the branch-equal flag and r31 to fetch.
module decode_regfile #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned LINK_REG = 31
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [31:0]       Inst,
    input  logic              RegWrite,
    input  logic              RegDst,
    input  logic              Link,
    input  logic              SignExt,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] LinkData,
    output logic [5:0]        Opcode,
    output logic [5:0]        Funct,
    output logic [4:0]        Shamt,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] Imm_ext,
    output logic              Zero,
    output logic [DATA_W-1:0] reg31
);

    localparam int unsigned AW = $clog2(NREGS);
    localparam logic [AW-1:0] LinkAddr = AW'(LINK_REG);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    logic [AW-1:0] rs, rt, rd, waddr;

    assign rs    = Inst[25:21];
    assign rt    = Inst[20:16];
    assign rd    = Inst[15:11];
    assign waddr = RegDst ? rd : rt;

    assign Opcode = Inst[31:26];
    assign Funct  = Inst[5:0];
    assign Shamt  = Inst[10:6];

    assign Imm_ext = {{(DATA_W-16){Inst[15] & SignExt}}, Inst[15:0]};

    // Reads come straight from the array: a same-cycle write is only visible after the edge.
    assign ReadData1 = regs_q[rs];
    assign ReadData2 = regs_q[rt];
    assign reg31     = regs_q[LinkAddr];
    assign Zero      = (ReadData1 == ReadData2);

    always_comb begin
        regs_d = regs_q;
        if (Link) begin
            regs_d[LinkAddr] = LinkData;
        end else if (RegWrite) begin
            regs_d[waddr] = WriteData;
        end
        // r0 is hard-wired: any write aimed at it is dropped here so reads never need a mux.
        regs_d[0] = '0;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: tb/tb_decode_regfile.sv
// Bench for decode_regfile: directed vectors queue expected values, a negedge monitor
// pops and compares them against the live outputs.
module tb_decode_regfile;

    logic        Clock;
    logic        Reset;
    logic [31:0] Inst;
    logic        RegWrite;
    logic        RegDst;
    logic        Link;
    logic        SignExt;
    logic [31:0] WriteData;
    logic [31:0] LinkData;
    logic [5:0]  Opcode;
    logic [5:0]  Funct;
    logic [4:0]  Shamt;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [31:0] Imm_ext;
    logic        Zero;
    logic [31:0] reg31;

    decode_regfile #(
        .DATA_W  (32),
        .NREGS   (32),
        .LINK_REG(31)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Inst     (Inst),
        .RegWrite (RegWrite),
        .RegDst   (RegDst),
        .Link     (Link),
        .SignExt  (SignExt),
        .WriteData(WriteData),
        .LinkData (LinkData),
        .Opcode   (Opcode),
        .Funct    (Funct),
        .Shamt    (Shamt),
        .ReadData1(ReadData1),
        .ReadData2(ReadData2),
        .Imm_ext  (Imm_ext),
        .Zero     (Zero),
        .reg31    (reg31)
    );

    typedef enum int {SigRd1, SigRd2, SigImm, SigZero, SigR31, SigOp, SigFunct, SigShamt} sig_e;

    typedef struct {
        string       name;
        sig_e        sig;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic [31:0] mon_act;
    int checks   = 0;
    int failures = 0;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    function automatic logic [31:0] actual(input sig_e s);
        case (s)
            SigRd1:   return ReadData1;
            SigRd2:   return ReadData2;
            SigImm:   return Imm_ext;
            SigZero:  return {31'b0, Zero};
            SigR31:   return reg31;
            SigOp:    return {26'b0, Opcode};
            SigFunct: return {26'b0, Funct};
            default:  return {27'b0, Shamt};
        endcase
    endfunction

    // Monitor: every expectation queued during a cycle is checked at that cycle's negedge.
    always @(negedge Clock) begin
        while (sb_q.size() > 0) begin
            mon_e   = sb_q.pop_front();
            mon_act = actual(mon_e.sig);
            checks++;
            if (mon_act !== mon_e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", mon_e.name, mon_act, mon_e.val);
            end
        end
    end

    task automatic expect_val(input string name, input sig_e s, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.sig  = s;
        e.val  = v;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic rst, input logic [31:0] inst, input logic rw,
                         input logic dst, input logic lnk, input logic sext,
                         input logic [31:0] wd, input logic [31:0] ld);
        Reset     = rst;
        Inst      = inst;
        RegWrite  = rw;
        RegDst    = dst;
        Link      = lnk;
        SignExt   = sext;
        WriteData = wd;
        LinkData  = ld;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        // Reset with a pending write that must be discarded.
        drive(1, 32'h00221820, 1, 1, 0, 1, 32'hDEADBEEF, 32'h0);
        tick();
        drive(0, 32'h00221820, 0, 1, 0, 1, 32'h0, 32'h0);
        expect_val("rst_rd1", SigRd1, 32'h0);
        expect_val("rst_rd2", SigRd2, 32'h0);
        expect_val("rst_zero", SigZero, 32'h1);
        expect_val("rst_r31", SigR31, 32'h0);
        tick();
        // r3 must not hold the discarded reset-cycle write.
        drive(0, 32'h00600000, 0, 0, 0, 1, 32'h0, 32'h0);
        expect_val("rst_r3", SigRd1, 32'h0);
        tick();

        // addi-style write of r1 = 5 via rt.
        drive(0, 32'h2001FFFF, 1, 0, 0, 1, 32'h5, 32'h0);
        expect_val("wr_pre_rd2", SigRd2, 32'h0);
        expect_val("wr_imm_sext", SigImm, 32'hFFFFFFFF);
        expect_val("wr_opcode", SigOp, 32'h08);
        tick();
        drive(0, 32'h2001FFFF, 0, 0, 0, 0, 32'h0, 32'h0);
        expect_val("wr_post_rd2", SigRd2, 32'h5);
        expect_val("wr_imm_zext", SigImm, 32'h0000FFFF);
        tick();

        // Positive immediate sign-extends with zeros; write r2 = 5.
        drive(0, 32'h3C027FFF, 1, 0, 0, 1, 32'h5, 32'h0);
        expect_val("imm_pos", SigImm, 32'h00007FFF);
        expect_val("imm_op", SigOp, 32'h0F);
        tick();

        // R-type add r3, r1, r2 with r3 = 10.
        drive(0, 32'h00221820, 1, 1, 0, 1, 32'hA, 32'h0);
        expect_val("rt_rd1", SigRd1, 32'h5);
        expect_val("rt_rd2", SigRd2, 32'h5);
        expect_val("rt_zero", SigZero, 32'h1);
        expect_val("rt_opcode", SigOp, 32'h0);
        expect_val("rt_funct", SigFunct, 32'h20);
        tick();
        // sll r2, r3, 2 as a read of r3 through rt.
        drive(0, 32'h00031080, 0, 0, 0, 1, 32'h0, 32'h0);
        expect_val("rt_r3", SigRd2, 32'hA);
        expect_val("rt_zero_ne", SigZero, 32'h0);
        expect_val("rt_shamt", SigShamt, 32'h2);
        expect_val("rt_funct0", SigFunct, 32'h0);
        tick();

        // Write to r0 is ignored.
        drive(0, 32'h00000020, 1, 1, 0, 1, 32'h12345678, 32'h0);
        tick();
        drive(0, 32'h00000000, 0, 0, 0, 1, 32'h0, 32'h0);
        expect_val("r0_rd1", SigRd1, 32'h0);
        expect_val("r0_zero", SigZero, 32'h1);
        tick();

        // Ordinary RegWrite to r31 shows on reg31, only after the edge.
        drive(0, 32'h0000F820, 1, 1, 0, 1, 32'h77, 32'h0);
        expect_val("r31_pre", SigR31, 32'h0);
        tick();
        drive(0, 32'h00000000, 0, 0, 0, 1, 32'h0, 32'h0);
        expect_val("r31_post", SigR31, 32'h77);
        tick();

        // Link beats RegWrite aimed at r5.
        drive(0, 32'h00002820, 1, 1, 1, 1, 32'hFFFFFFFF, 32'h1C);
        expect_val("lnk_pre", SigR31, 32'h77);
        tick();
        drive(0, 32'h00A00000, 0, 0, 0, 1, 32'h0, 32'h0);
        expect_val("lnk_r31", SigR31, 32'h1C);
        expect_val("lnk_r5", SigRd1, 32'h0);
        tick();

        // Reset overrides a link write in the same cycle.
        drive(1, 32'h00220000, 0, 0, 1, 1, 32'h0, 32'h40);
        tick();
        drive(0, 32'h00220000, 0, 0, 0, 1, 32'h0, 32'h0);
        expect_val("mrst_r31", SigR31, 32'h0);
        expect_val("mrst_r1", SigRd1, 32'h0);
        expect_val("mrst_r2", SigRd2, 32'h0);
        tick();
        drive(0, 32'h03E00000, 0, 0, 1, 1, 32'h0, 32'h40);
        tick();
        drive(0, 32'h03E00000, 0, 0, 0, 1, 32'h0, 32'h0);
        expect_val("mrst_link", SigR31, 32'h40);
        expect_val("mrst_rd31", SigRd1, 32'h40);

        @(negedge Clock);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_regfile.md
Name: decode_regfile

Overview:
Decode and register-file stage directly downstream of instruction fetch in the single-cycle CPU. It consumes the fetched 32-bit instruction word and splits it into fields. It holds the 32x32 general-purpose register file and produces the operands and the extended immediate. It also feeds back to fetch the branch-equal flag (Zero) and the current contents of r31 (reg31), which fetch uses for jump-register returns.

Parameters:
DATA_W, 32, register and data width
NREGS, 32, number of architectural registers (address width 5)
LINK_REG, 31, register index written by link (jal) operations

Ports:
Clock  in  1  system clock, rising-edge active
Reset  in  1  synchronous, active-high reset
Inst  in  32  instruction word from fetch
RegWrite  in  1  write-enable for WriteData
RegDst  in  1  write address select: 1 = rd (Inst[15:11]), 0 = rt (Inst[20:16])
Link  in  1  write LinkData into r[LINK_REG] this cycle
SignExt  in  1  immediate extension: 1 = sign, 0 = zero
WriteData  in  32  ALU/memory result to write back
LinkData  in  32  return address (PC+4) from fetch
Opcode  out  6  Inst[31:26]
Funct  out  6  Inst[5:0]
Shamt  out  5  Inst[10:6]
ReadData1  out  32  r[rs], rs = Inst[25:21]
ReadData2  out  32  r[rt], rt = Inst[20:16]
Imm_ext  out  32  Inst[15:0] extended per SignExt
Zero  out  1  1 when ReadData1 == ReadData2
reg31  out  32  current contents of r[LINK_REG]

Behaviour:
- Storage: NREGS x DATA_W register array; all state in this array.
- Reset: on a rising Clock edge with Reset=1, every register is cleared to 0. Reset overrides Link and RegWrite in the same cycle. After reset, ReadData1, ReadData2 and reg31 read 0, and Zero=1.
- Reset mid-operation: a pending write in the reset cycle is discarded. No partial state is kept.
- Reads: asynchronous and combinational from the array. No write-through bypass. A read in the same cycle as a write to the same register returns the pre-edge value. The new value is visible after the edge.
- r0: always reads 0. Any write addressed to r0 is ignored, including RegWrite with a write address of 0.
- Write port: one write per rising edge when Reset=0.
  - Link=1: r[LINK_REG] <= LinkData. RegWrite is ignored that cycle, so Link has priority.
  - Link=0, RegWrite=1: r[waddr] <= WriteData, with waddr = RegDst ? Inst[15:11] : Inst[20:16].
  - Link=0, RegWrite=0: no change.
- Field decode: Opcode, Funct and Shamt are combinational slices of Inst, with zero latency.
- Imm_ext: SignExt=1 gives {16{Inst[15]}, Inst[15:0]}. SignExt=0 gives {16'h0, Inst[15:0]}.
- Zero: combinational full 32-bit equality of ReadData1 and ReadData2.
- reg31: combinational view of r[LINK_REG], including updates made by ordinary RegWrite to register 31.
- Latency: write-to-read latency is one edge. All outputs are valid in the same cycle as their inputs.
- Unknown inputs: X on Link or RegWrite during non-reset is not required to be handled. Benches hold control inputs at 0/1.

Test Plan:
- Reset: assert Reset for 1 edge with RegWrite=1, WriteData=32'hDEADBEEF, Inst=32'h00221820 -> all reads 0, reg31=0, Zero=1, no register written.
- Write/read: Inst=32'h2001FFFF, RegDst=0, RegWrite=1, WriteData=32'h00000005. Before the edge ReadData2=0. After the edge r1=5. Imm_ext=32'hFFFFFFFF with SignExt=1, and 32'h0000FFFF with SignExt=0.
- R-type: after r1=5 and r2=5 are written, Inst=32'h00221820 -> ReadData1=5, ReadData2=5, Zero=1, Opcode=0, Funct=6'h20. Then RegDst=1, WriteData=32'hA -> r3=10.
- r0 protection: RegWrite=1, RegDst=1, Inst rd=0, WriteData=32'h12345678 -> r0 still reads 0.
- Link priority: Link=1, RegWrite=1, LinkData=32'h0000001C, WriteData=32'hFFFFFFFF, target r5 -> reg31=32'h1C, r5 unchanged.
- Reset mid-operation: after r31=32'h1C, assert Reset with Link=1 and LinkData=32'h40 -> reg31=0 after the edge. Deassert and issue one link write -> reg31=32'h40.
